// File: rtl/mux_n_1_rr.sv
// N-to-1 streaming mux with valid/ready on every channel and a one-beat registered output.
// Define MUX_RR_EN to add the mode port and a round-robin arbiter; otherwise select is external only.
module mux_n_1_rr #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic [SW-1:0]  sel,
`ifdef MUX_RR_EN
   input  logic           mode,
`endif
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_ch,
   output logic           out_valid,
   input  logic           out_ready
);

   logic [W-1:0]  out_data_r;
   logic [SW-1:0] out_ch_r;
   logic          out_valid_r;
   logic          can_load_s;
   logic          grant_vld_s;
   logic [SW-1:0] grant_s;
   logic [SW:0]   pick_s;
   logic [W-1:0]  grant_data_s;
   logic [N-1:0]  in_ready_s;
   logic          xfer_s;

   // External select: a grant only for an in-range, valid channel.
   function automatic logic [SW:0] sel_pick(input logic [N-1:0] v, input logic [SW-1:0] s);
      logic [SW:0] res;
      res = '0;
      if (int'(s) < N) begin
         if (v[s]) begin
            res = {1'b1, s};
         end else begin
            res = '0;
         end
      end else begin
         res = '0;
      end
      return res;
   endfunction

`ifdef MUX_RR_EN
   logic [SW-1:0] rr_ptr_r;

   // Scan descending by offset so the channel closest to ptr wins.
   function automatic logic [SW:0] rr_pick(input logic [N-1:0] v, input logic [SW-1:0] ptr);
      logic [SW:0] res;
      int          k;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         k = int'(ptr) + i;
         if (k >= N) begin
            k = k - N;
         end else begin
            k = k;
         end
         if (v[k]) begin
            res = {1'b1, SW'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`endif

   assign can_load_s = !out_valid_r || out_ready;

   // Grant selection for the current cycle.
   always_comb begin
      pick_s = '0;
`ifdef MUX_RR_EN
      if (mode) begin
         pick_s = rr_pick(in_valid, rr_ptr_r);
      end else begin
         pick_s = sel_pick(in_valid, sel);
      end
`else
      pick_s = sel_pick(in_valid, sel);
`endif
      grant_vld_s  = pick_s[SW];
      grant_s      = pick_s[SW-1:0];
      grant_data_s = in_data[int'(grant_s)*W +: W];
   end

   // Only the granted channel sees ready, and never while reset is asserted.
   always_comb begin
      in_ready_s = '0;
      if (grant_vld_s && !rst) begin
         in_ready_s[grant_s] = can_load_s;
      end else begin
         in_ready_s = '0;
      end
   end

   assign xfer_s = grant_vld_s && can_load_s && !rst;

   // Output register: load on transfer, otherwise drain when the consumer takes the beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
      end else if (xfer_s) begin
         out_data_r  <= grant_data_s;
         out_ch_r    <= grant_s;
         out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

`ifdef MUX_RR_EN
   // Round-robin pointer moves past the channel just served.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r <= '0;
      end else if (xfer_s && mode) begin
         rr_ptr_r <= (grant_s == SW'(N - 1)) ? '0 : grant_s + 1'b1;
      end
   end
`endif

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: directed vectors push expected beats, a monitor pops on each output handshake.
// Round-robin vectors run only when MUX_RR_EN is defined; a second N=3 instance covers the out-of-range select.
module tb_mux_n_1_rr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = 32'h0;
   logic [3:0]  in_valid = 4'hF;
   logic [3:0]  in_ready;
   logic [1:0]  sel = 2'd0;
   logic        mode_a = 1'b0;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready = 1'b1;

   logic [23:0] in_data_b = 24'h0;
   logic [2:0]  in_valid_b = 3'b000;
   logic [2:0]  in_ready_b;
   logic [1:0]  sel_b = 2'd0;
   logic [7:0]  out_data_b;
   logic [1:0]  out_ch_b;
   logic        out_valid_b;

   int tests = 0;
   int fails = 0;
   logic [9:0] sb_q[$];

   always #5 clk = ~clk;

   mux_n_1_rr #(.N(4), .W(8)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel),
`ifdef MUX_RR_EN
      .mode(mode_a),
`endif
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_n_1_rr #(.N(3), .W(8)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .sel(sel_b),
`ifdef MUX_RR_EN
      .mode(1'b0),
`endif
      .out_data(out_data_b), .out_ch(out_ch_b), .out_valid(out_valid_b), .out_ready(1'b1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus on dut_a; the hand-computed ready vector says which beat is accepted.
   task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [1:0] s,
                       input logic m, input logic ordy, input logic [3:0] exp_rdy, input string name);
      @(posedge clk);
      #1;
      rst = r; in_valid = v; in_data = d; sel = s; mode_a = m; out_ready = ordy;
      @(negedge clk);
      chk({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
         if (exp_rdy[i] && v[i]) sb_q.push_back({2'(i), d[i*8 +: 8]});
      end
   endtask

   // Monitor: every consumed output beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected beat: got ch %0d data %0h, expected none", out_ch, out_data);
         end else begin
            logic [9:0] e;
            e = sb_q.pop_front();
            chk("beat data", 32'(out_data), 32'(e[7:0]));
            chk("beat ch", 32'(out_ch), 32'(e[9:8]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      // Reset with every channel valid: nothing accepted, outputs cleared.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 4'hF, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1, 4'h0, "reset");
         chk("reset out_valid", 32'(out_valid), 32'd0);
         chk("reset out_data", 32'(out_data), 32'd0);
         chk("reset out_ch", 32'(out_ch), 32'd0);
      end

      // Mode 0 basic transfer on channel 2.
      step(1'b0, 4'b0100, 32'h00A50000, 2'd2, 1'b0, 1'b1, 4'b0100, "sel2");
      step(1'b0, 4'b0010, 32'h00001100, 2'd2, 1'b0, 1'b1, 4'b0000, "sel2 not valid");
      chk("sel2 out_valid", 32'(out_valid), 32'd1);

      // Backpressure: 3C held for five cycles, then drain and load together.
      step(1'b0, 4'b1000, 32'h3C000000, 2'd3, 1'b0, 1'b0, 4'b1000, "bp load");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b0001, 32'h00000011, 2'd0, 1'b0, 1'b0, 4'b0000, "bp hold");
         chk("bp hold data", 32'(out_data), 32'h3C);
         chk("bp hold ch", 32'(out_ch), 32'd3);
         chk("bp hold valid", 32'(out_valid), 32'd1);
      end
      step(1'b0, 4'b0001, 32'h00000077, 2'd0, 1'b0, 1'b1, 4'b0001, "bp drain+load");
      step(1'b0, 4'b0000, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0000, "bp idle");
      chk("drain+load out_valid", 32'(out_valid), 32'd1);

      // Full throughput with the select moving each cycle.
      step(1'b0, 4'hF, 32'h44332211, 2'd1, 1'b0, 1'b1, 4'b0010, "tput s1");
      step(1'b0, 4'hF, 32'h88776655, 2'd2, 1'b0, 1'b1, 4'b0100, "tput s2");
      step(1'b0, 4'hF, 32'hCCBBAA99, 2'd3, 1'b0, 1'b1, 4'b1000, "tput s3");
      step(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0000, "tput idle");

`ifdef MUX_RR_EN
      // Round-robin with all channels valid, then only channels 0 and 3.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'hF, 32'h40302010 + 32'(i), 2'd2, 1'b1, 1'b1, 4'(1 << (i % 4)), "rr all");
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b1001, 32'hF00000E0 + 32'(i), 2'd2, 1'b1, 1'b1,
              (i % 2 == 0) ? 4'b0001 : 4'b1000, "rr 1001");
      end
      step(1'b0, 4'h0, 32'h0, 2'd0, 1'b1, 1'b1, 4'b0000, "rr idle");
`endif

      // Reset mid-stream: a held beat is discarded and the pointer returns to channel 0.
      step(1'b0, 4'b0010, 32'h00005A00, 2'd1, 1'b1, 1'b0, 4'b0010, "mid load");
      step(1'b0, 4'b0000, 32'h0, 2'd1, 1'b1, 1'b0, 4'b0000, "mid hold");
      chk("mid hold valid", 32'(out_valid), 32'd1);
      sb_q.delete();
      step(1'b1, 4'hF, 32'h0, 2'd1, 1'b1, 1'b0, 4'b0000, "mid reset");
      step(1'b0, 4'hF, 32'h44332266, 2'd0, 1'b1, 1'b0, 4'b0001, "after reset");
      chk("after reset out_valid", 32'(out_valid), 32'd0);
      step(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0000, "after reset drain");
      step(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0000, "final idle");
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

      // N=3 instance: select 3 is out of range and must never be granted.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         in_valid_b = 3'b111; sel_b = 2'd3; in_data_b = 24'h332211;
         @(negedge clk);
         chk("n3 sel3 in_ready", 32'(in_ready_b), 32'd0);
         chk("n3 sel3 out_valid", 32'(out_valid_b), 32'd0);
      end
      @(posedge clk);
      #1;
      sel_b = 2'd2;
      @(negedge clk);
      chk("n3 sel2 in_ready", 32'(in_ready_b), 32'b100);
      @(posedge clk);
      #1;
      in_valid_b = 3'b000;
      @(negedge clk);
      chk("n3 sel2 out_valid", 32'(out_valid_b), 32'd1);
      chk("n3 sel2 out_data", 32'(out_data_b), 32'h33);
      chk("n3 sel2 out_ch", 32'(out_ch_b), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mux_n_1_rr.md
# mux_n_1_rr

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every input channel and on the output, and a one-beat registered output stage. Channel choice comes from an external select or, when compiled in, a round-robin arbiter. It is the sequential, multi-channel successor to the team's 2:1 gate-level mux. It sits between several producer streams and a single consumer.

## Interface

Parameters:

- N, 4, number of input channels (N ≥ 2).
- W, 8, data width per channel.
- SW, $clog2(N), select and channel-index width.

Ports:

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- sel  input  SW  external channel select (mode 0).
- mode  input  1  0 = external select, 1 = round-robin. Present only with MUX_RR_EN.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  consumer ready.

## Operation

- Output register state: out_data, out_ch, out_valid. Internal state: rr_ptr (SW bits).
- can_load = !out_valid || out_ready.
- Grant selection is combinational:
  - Mode 0: grant channel sel if sel < N and in_valid[sel]. Otherwise no grant.
  - Mode 1: grant the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1.
- in_ready[g] = can_load for the granted channel g. in_ready is 0 for every other channel, and all 0 when there is no grant.
- Transfer on channel g (in_valid[g] && in_ready[g]) at a clock edge:
  - out_data ← in_data[g], out_ch ← g, out_valid ← 1.
- Otherwise, if out_valid && out_ready: out_valid ← 0. out_data and out_ch hold their values.
- rr_ptr ← (g == N-1) ? 0 : g+1 on every mode-1 transfer. rr_ptr is unchanged in mode 0.
- While out_valid && !out_ready, out_data and out_ch stay stable and all in_ready are 0.
- in_ready never depends on out_valid of the same cycle except through can_load. There is no combinational path from in_valid to in_ready of a different channel beyond the grant scan.
- sel ≥ N (when N is not a power of two): no grant, nothing accepted.

## Timing

- Reset (rst high at a clock edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all 0 during the reset cycle.
- Reset asserted mid-stream discards the held beat. No input transfer is recorded in that cycle.
- Latency: 1 cycle, from an input transfer edge to out_valid high.
- Throughput: 1 beat per cycle while out_ready stays high. A simultaneous drain and load in the same cycle leaves out_valid high with the new beat.
- A mode or sel change takes effect on the next grant evaluation. A held output beat is unaffected.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once every N cycles.

## Configuration

- MUX_RR_EN defined:
  - The mode port and rr_ptr exist.
  - Round-robin arbitration is selectable as described above.
- MUX_RR_EN undefined:
  - The mode port and rr_ptr are removed.
  - The block always behaves as mode 0 (external select only). All other behaviour is identical.

## Test plan

- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout.
- Mode 0, N=4, W=8: sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=A5, out_ch=2.
- Backpressure: hold out_ready=0 after a beat of 8'h3C -> out_data stays 3C and in_ready=0 for 5 cycles. When out_ready returns to 1 with a new valid input, 3C drains and the new beat loads in the same cycle.
- Round-robin (MUX_RR_EN): all in_valid=1 and out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1001 -> out_ch alternates 0,3, and rr_ptr wraps 3→0.
- Invalid select, N=3: sel=3 with all in_valid=1 -> in_ready=0 and out_valid stays 0.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> the next cycle shows out_valid=0, and rr_ptr=0 (first grant afterwards is channel 0).
